up_counter16_4: RTL and testbench

Bank of four 16-bit up counters on one clock, with per-channel enable, clear, terminal-count pulse and sticky overflow flag. Includes a coherent snapshot/readout port: one request captures all four counts at the same instant. The captured values are then streamed out one channel per transfer over a valid/ready handshake. It is the counting-up companion to the down-counter bank and is used by monitor/test logic that needs atomic multi-counter reads.

---
 rtl/up_counter16_4_if.sv | 19 +
 rtl/up_counter16_4.sv | 95 +++++++++
 tb/tb_up_counter16_4.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/up_counter16_4_if.sv
// up_counter16_4_if: snapshot request and readout stream of the up_counter16_4 bank.
//   snap_req  consumer -> bank   single-cycle snapshot request
//   snap_busy bank -> consumer   readout in progress
//   rd_valid  bank -> consumer   readout word valid
//   rd_ready  consumer -> bank   readout word accepted
//   rd_chan   bank -> consumer   channel index of rd_data
//   rd_data   bank -> consumer   captured count
//   rd_last   bank -> consumer   high with the channel 3 word
interface up_counter16_4_if #(parameter int WIDTH = 16);
  logic             snap_req;
  logic             snap_busy;
  logic             rd_valid;
  logic             rd_ready;
  logic [1:0]       rd_chan;
  logic [WIDTH-1:0] rd_data;
  logic             rd_last;
  modport master (input snap_req, rd_ready, output snap_busy, rd_valid, rd_chan, rd_data, rd_last);
  modport slave (output snap_req, rd_ready, input snap_busy, rd_valid, rd_chan, rd_data, rd_last);
endinterface

// File: rtl/up_counter16_4.sv
// up_counter16_4: four independent up counters with coherent snapshot readout.
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   en, clr        per-channel count enable / synchronous clear (clr wins)
//   cnt0_16..3_16  live counts
//   tc             per-channel terminal-count (pulse on wrap, level when saturating)
//   ovf            per-channel sticky overflow, cleared by clr or reset
//   rd             snapshot/readout stream (up_counter16_4_if master side)
// Define UP_COUNTER_SAT_EN to saturate at LIMIT instead of wrapping to 0.
module up_counter16_4 #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       en,
  input  logic [3:0]       clr,
  output logic [WIDTH-1:0] cnt0_16,
  output logic [WIDTH-1:0] cnt1_16,
  output logic [WIDTH-1:0] cnt2_16,
  output logic [WIDTH-1:0] cnt3_16,
  output logic [3:0]       tc,
  output logic [3:0]       ovf,
  up_counter16_4_if.master rd
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t           state;
  logic [WIDTH-1:0] cnt [4];
  logic [WIDTH-1:0] nxt [4];
  logic [WIDTH-1:0] shadow [4];
  logic [WIDTH-1:0] data_q;
  logic [3:0]       wrap;
  logic [1:0]       idx;
  logic [1:0]       nidx;
  logic             last_q;
  assign cnt0_16 = cnt[0];
  assign cnt1_16 = cnt[1];
  assign cnt2_16 = cnt[2];
  assign cnt3_16 = cnt[3];
  assign nidx = idx + 1'b1;
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wrap[k] = !clr[k] && en[k] && cnt[k] == LIMIT;
`ifdef UP_COUNTER_SAT_EN
      nxt[k] = clr[k] ? '0 : (en[k] && cnt[k] != LIMIT) ? cnt[k] + 1'b1 : cnt[k];
`else
      nxt[k] = (clr[k] || wrap[k]) ? '0 : en[k] ? cnt[k] + 1'b1 : cnt[k];
`endif
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '{default: '0};
      tc  <= '0;
      ovf <= '0;
    end else begin
      cnt <= nxt;
      ovf <= ~clr & (ovf | wrap);
`ifdef UP_COUNTER_SAT_EN
      for (int k = 0; k < 4; k++) tc[k] <= !clr[k] && nxt[k] == LIMIT;
`else
      tc <= wrap;
`endif
    end
  end
  // rd_chan is idx itself; rd_data is preloaded with the word for the next idx,
  // which after channel 3 wraps back to shadow[0] as required in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= '{default: '0};
      data_q <= '0;
      last_q <= 1'b0;
    end else if (state == IDLE) begin
      if (rd.snap_req) begin
        shadow <= cnt;
        idx    <= '0;
        data_q <= cnt[0];
        last_q <= 1'b0;
        state  <= SEND;
      end
    end else if (rd.rd_ready) begin
      idx    <= nidx;
      data_q <= shadow[nidx];
      last_q <= idx == 2'd2;
      state  <= idx == 2'd3 ? IDLE : SEND;
    end
  end
  assign rd.rd_valid  = state == SEND;
  assign rd.snap_busy = state == SEND;
  assign rd.rd_chan   = idx;
  assign rd.rd_data   = data_q;
  assign rd.rd_last   = last_q;
endmodule

// File: tb/tb_up_counter16_4.sv
// tb_up_counter16_4: directed and randomized checks of up_counter16_4 against a behavioural model.
module tb_up_counter16_4;
  localparam logic [15:0] LIMIT = 16'd100;
`ifdef UP_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  en = '0, clr = '0;
  logic [15:0] c0, c1, c2, c3;
  logic [3:0]  tc, ovf;
  int          checks = 0, errors = 0;
  logic [15:0] m_cnt [4];
  logic [3:0]  m_tc, m_ovf;
  logic [15:0] m_sh0;
  logic [15:0] q [$];
  up_counter16_4_if #(.WIDTH(16)) rd ();
  up_counter16_4 #(.WIDTH(16), .LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .cnt0_16(c0), .cnt1_16(c1), .cnt2_16(c2), .cnt3_16(c3),
    .tc(tc), .ovf(ovf), .rd(rd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic word(input int ch, input int d, input bit last);
    chk("word_valid", rd.rd_valid, 1);
    chk("word_chan", rd.rd_chan, ch);
    chk("word_data", rd.rd_data, d);
    chk("word_last", rd.rd_last, last);
  endtask
  // The readout is a queue of the four captured counts; the channel on offer
  // is 4 minus the number still waiting.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = '0;
      m_tc = '0;
      m_ovf = '0;
      m_sh0 = '0;
      q.delete();
    end else begin
      if (q.size() != 0) begin
        if (rd.rd_ready) void'(q.pop_front());
      end else if (rd.snap_req) begin
        for (int k = 0; k < 4; k++) q.push_back(m_cnt[k]);
        m_sh0 = m_cnt[0];
      end
      for (int k = 0; k < 4; k++) begin
        m_tc[k] = 1'b0;
        if (clr[k]) begin
          m_cnt[k] = '0;
          m_ovf[k] = 1'b0;
        end else if (en[k]) begin
          if (m_cnt[k] == LIMIT) begin
            m_ovf[k] = 1'b1;
            if (!SAT) begin
              m_cnt[k] = '0;
              m_tc[k] = 1'b1;
            end
          end else m_cnt[k] = m_cnt[k] + 16'd1;
        end
        if (SAT) m_tc[k] = m_cnt[k] == LIMIT;
      end
    end
  end
  always @(negedge clk) begin
    if (reset) begin
      chk("cnt0", c0, m_cnt[0]);
      chk("cnt1", c1, m_cnt[1]);
      chk("cnt2", c2, m_cnt[2]);
      chk("cnt3", c3, m_cnt[3]);
      chk("tc", tc, m_tc);
      chk("ovf", ovf, m_ovf);
      chk("rd_valid", rd.rd_valid, q.size() != 0);
      chk("snap_busy", rd.snap_busy, q.size() != 0);
      chk("rd_chan", rd.rd_chan, q.size() != 0 ? 4 - q.size() : 0);
      chk("rd_data", rd.rd_data, q.size() != 0 ? q[0] : m_sh0);
      chk("rd_last", rd.rd_last, q.size() == 1);
    end
  end
  initial begin
    rd.snap_req = 1'b0;
    rd.rd_ready = 1'b0;
    #1 reset = 1'b0;
    #3;
    chk("rst_cnt0", c0, 0);
    chk("rst_tc", tc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_valid", rd.rd_valid, 0);
    chk("rst_data", rd.rd_data, 0);
    #8 reset = 1'b1;
    tick(1);
    en = 4'b1111;
    tick(5);
    en = 4'b0000;
    chk("five_cnt0", c0, 5);
    chk("five_cnt3", c3, 5);
    chk("five_tc", tc, 0);
    chk("five_valid", rd.rd_valid, 0);
    clr = 4'b1111;
    tick(1);
    clr = 4'b0000;
    en = 4'b0001;
    tick(int'(LIMIT) - 1);
    chk("pre_lim", c0, LIMIT - 16'd1);
    tick(1);
    chk("at_lim", c0, LIMIT);
    chk("at_lim_tc", tc[0], SAT);
    tick(1);
    chk("wrap_cnt", c0, SAT ? LIMIT : 16'd0);
    chk("wrap_tc", tc[0], 1);
    chk("wrap_ovf", ovf[0], 1);
    en = 4'b0000;
    tick(1);
    chk("post_tc", tc[0], SAT);
    tick(3);
    chk("ovf_sticky", ovf[0], 1);
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    chk("ovf_clr", ovf[0], 0);
    en = 4'b0010;
    tick(7);
    chk("cnt1_7", c1, 7);
    clr = 4'b0010;
    tick(1);
    clr = 4'b0000;
    en = 4'b0000;
    chk("clr_cnt1", c1, 0);
    chk("clr_ovf1", ovf[1], 0);
    chk("clr_tc1", tc[1], 0);
    clr = 4'b1111;
    tick(1);
    clr = 4'b0000;
    en = 4'b1111; tick(10);
    en = 4'b1110; tick(10);
    en = 4'b1100; tick(10);
    en = 4'b1000; tick(10);
    en = 4'b1111;
    rd.snap_req = 1'b1;
    rd.rd_ready = 1'b1;
    tick(1);
    rd.snap_req = 1'b0;
    word(0, 10, 0); tick(1);
    word(1, 20, 0); tick(1);
    word(2, 30, 0); tick(1);
    word(3, 40, 1); tick(1);
    chk("done_valid", rd.rd_valid, 0);
    chk("done_busy", rd.snap_busy, 0);
    chk("live_cnt0", c0, 15);
    chk("live_cnt3", c3, 45);
    en = 4'b0000;
    rd.snap_req = 1'b1;
    rd.rd_ready = 1'b0;
    tick(1);
    rd.snap_req = 1'b0;
    word(0, 15, 0);
    tick(2);
    word(0, 15, 0);
    rd.snap_req = 1'b1;
    rd.rd_ready = 1'b1;
    tick(1);
    rd.snap_req = 1'b0;
    rd.rd_ready = 1'b0;
    word(1, 25, 0);
    tick(1);
    word(1, 25, 0);
    rd.rd_ready = 1'b1;
    tick(1);
    word(2, 35, 0);
    tick(1);
    word(3, 45, 1);
    rd.rd_ready = 1'b0;
    tick(1);
    word(3, 45, 1);
    chk("stall_busy", rd.snap_busy, 1);
    rd.rd_ready = 1'b1;
    tick(1);
    chk("end_busy", rd.snap_busy, 0);
    tick(2);
    chk("no_queue", rd.rd_valid, 0);
    en = 4'b1111;
    rd.snap_req = 1'b1;
    tick(1);
    rd.snap_req = 1'b0;
    tick(2);
    chk("mid_chan", rd.rd_chan, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", rd.rd_valid, 0);
    chk("arst_busy", rd.snap_busy, 0);
    chk("arst_cnt0", c0, 0);
    chk("arst_data", rd.rd_data, 0);
    #2 reset = 1'b1;
    tick(1);
    for (int i = 0; i < 3000; i++) begin
      en = 4'($urandom);
      clr = ($urandom % 16 == 0) ? 4'($urandom) : 4'b0000;
      rd.snap_req = $urandom % 6 == 0;
      rd.rd_ready = $urandom % 3 != 0;
      if ($urandom % 400 == 0) begin
        #2 reset = 1'b0;
        #3 reset = 1'b1;
      end
      tick(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
